uart_cmd_decoder: RTL and testbench

Receive-side command decoder for the sensor/OLED controller. It consumes the byte stream delivered by the UART receiver (`donerx`/`doutrx`), validates framed host commands, and drives the `mode`, `I_Temp_war`, `I_Hum_war` and `trig_newd12` inputs of the measurement/display controller. It is the host-to-board counterpart of the 4-byte telemetry stream that the controller transmits.

---
 rtl/uart_cmd_decoder.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: receive-side host command decoder.
// Consumes bytes from the UART receiver, validates HEADER/CMD/DATA[/CHK]
// frames and updates the mode and alarm-threshold registers that feed the
// measurement/display controller.
// Optional feature: define CMD_CHECKSUM_EN for 4-byte frames whose last byte
// is CMD ^ DATA; without it frames are 3 bytes and evaluate on DATA.
//
// Byte handshake: donerx is a valid-only strobe with no ready back-pressure;
// the decoder consumes a byte in every cycle donerx is high, including
// consecutive cycles, so the receiver never has to wait.
module uart_cmd_decoder #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned TIMEOUT_CYC  = 12_500_000,
    parameter logic [6:0]  TEMP_WAR_RST = 7'd35,
    parameter logic [6:0]  HUM_WAR_RST  = 7'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       donerx,
    input  logic [7:0] doutrx,
    output logic [1:0] mode,
    output logic [6:0] I_Temp_war,
    output logic [6:0] I_Hum_war,
    output logic       trig_newd12,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic [1:0] dbg_state      // FSM state, 0 = S_IDLE
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       data_q, data_d;
`endif
    logic [1:0]       mode_q, mode_d;
    logic [6:0]       temp_q, temp_d;
    logic [6:0]       hum_q, hum_d;
    logic             trig_q, trig_d;
    logic             cmd_ok_q, cmd_ok_d;
    logic             cmd_err_q, cmd_err_d;

    // Frame evaluation helpers (valid only when eval is high).
    logic             eval;
    logic [7:0]       eval_data;
    logic             chk_ok;
    logic             cmd_valid;

    // Next-state, byte capture, timeout and frame evaluation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
`ifdef CMD_CHECKSUM_EN
        data_d    = data_q;
`endif
        mode_d    = mode_q;
        temp_d    = temp_q;
        hum_d     = hum_q;
        trig_d    = trig_q;
        cmd_ok_d  = 1'b0;
        cmd_err_d = 1'b0;
        eval      = 1'b0;
        eval_data = doutrx;
        chk_ok    = 1'b1;
        cmd_valid = 1'b0;

        if (donerx) begin
            // A byte always wins over a timeout firing in the same cycle.
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (doutrx == HEADER) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    // No resync here: a repeated HEADER is taken as CMD.
                    cmd_d   = doutrx;
                    state_d = S_DATA;
                end
                S_DATA: begin
`ifdef CMD_CHECKSUM_EN
                    data_d  = doutrx;
                    state_d = S_CHK;
`else
                    eval    = 1'b1;
                    state_d = S_IDLE;
`endif
                end
                S_CHK: begin
`ifdef CMD_CHECKSUM_EN
                    eval      = 1'b1;
                    eval_data = data_q;
                    chk_ok    = (doutrx == (cmd_q ^ data_q));
`endif
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                cmd_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (eval) begin
            // Range checks use the full data byte so bit 7 cannot alias.
            case (cmd_q)
                8'h01: cmd_valid = (eval_data[7:2] == 6'd0) && (eval_data[1:0] != 2'd3);
                8'h02: cmd_valid = (eval_data <= 8'd85);
                8'h03: cmd_valid = (eval_data <= 8'd100);
                default: cmd_valid = 1'b0;
            endcase

            if (cmd_valid && chk_ok) begin
                case (cmd_q)
                    8'h01:   mode_d = eval_data[1:0];
                    8'h02:   temp_d = eval_data[6:0];
                    default: hum_d  = eval_data[6:0];
                endcase
                trig_d   = ~trig_q;
                cmd_ok_d = 1'b1;
            end else begin
                cmd_err_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
`ifdef CMD_CHECKSUM_EN
            data_q    <= '0;
`endif
            mode_q    <= 2'd0;
            temp_q    <= TEMP_WAR_RST;
            hum_q     <= HUM_WAR_RST;
            trig_q    <= 1'b0;
            cmd_ok_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
`ifdef CMD_CHECKSUM_EN
            data_q    <= data_d;
`endif
            mode_q    <= mode_d;
            temp_q    <= temp_d;
            hum_q     <= hum_d;
            trig_q    <= trig_d;
            cmd_ok_q  <= cmd_ok_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign mode        = mode_q;
    assign I_Temp_war  = temp_q;
    assign I_Hum_war   = hum_q;
    assign trig_newd12 = trig_q;
    assign cmd_ok      = cmd_ok_q;
    assign cmd_err     = cmd_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: table of command frames with hand-derived
// results, hand-written timeout/reset sequences, and random frames checked
// every cycle against a frame-level reference model.
module tb_uart_cmd_decoder;

    localparam int T = 40;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef CMD_CHECKSUM_EN
    localparam int FLEN = 4;
    localparam logic CHK_ON = 1'b1;
`else
    localparam int FLEN = 3;
    localparam logic CHK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       donerx;
    logic [7:0] doutrx;
    logic [1:0] mode;
    logic [6:0] I_Temp_war;
    logic [6:0] I_Hum_war;
    logic       trig_newd12;
    logic       cmd_ok;
    logic       cmd_err;
    logic [1:0] dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_cmd_decoder #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .donerx(donerx), .doutrx(doutrx),
        .mode(mode), .I_Temp_war(I_Temp_war), .I_Hum_war(I_Hum_war),
        .trig_newd12(trig_newd12), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: bytes of the frame in progress plus idle-cycle count.
    logic [7:0]  frame_q[$];
    int          idle_cnt;
    logic [1:0]  m_mode;
    logic [6:0]  m_temp, m_hum;
    logic        m_trig, m_ok, m_err;
    logic [18:0] exp_q[$];

    typedef struct {
        string      name;
        logic [7:0] b [4];
        logic [1:0] e_mode;
        logic [6:0] e_temp;
        logic [6:0] e_hum;
        logic       e_ok;
        logic       e_err;
    } vec_t;

    localparam int NV = 16;
    vec_t       tbl [NV];
    logic       t_exp;
    logic [1:0] m4;
    logic [7:0] fb [4];
    int         gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        frame_q.delete();
        idle_cnt = 0;
        m_mode = 2'd0; m_temp = 7'd35; m_hum = 7'd80;
        m_trig = 1'b0; m_ok = 1'b0; m_err = 1'b0;
    endtask

    task automatic judge();
        logic [7:0] c, dt;
        logic good;
        c = frame_q[1];
        dt = frame_q[2];
        good = 1'b0;
`ifdef CMD_CHECKSUM_EN
        if (frame_q[3] == (c ^ dt))
`endif
        begin
            if (c == 8'd1 && dt <= 8'd2) begin m_mode = dt[1:0]; good = 1'b1; end
            else if (c == 8'd2 && dt <= 8'd85) begin m_temp = dt[6:0]; good = 1'b1; end
            else if (c == 8'd3 && dt <= 8'd100) begin m_hum = dt[6:0]; good = 1'b1; end
        end
        if (good) begin m_trig = ~m_trig; m_ok = 1'b1; end
        else m_err = 1'b1;
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d);
        m_ok = 1'b0;
        m_err = 1'b0;
        if (dv) begin
            idle_cnt = 0;
            if (frame_q.size() == 0) begin
                if (d == HDR) frame_q.push_back(d);
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == FLEN) begin
                    judge();
                    frame_q.delete();
                end
            end
        end else if (frame_q.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == T) begin
                m_err = 1'b1;
                frame_q.delete();
                idle_cnt = 0;
            end
        end
        exp_q.push_back({m_mode, m_temp, m_hum, m_trig, m_ok, m_err});
    endtask

    // Driver: one clock cycle, optionally carrying a byte; checks the cycle.
    task automatic cycle(input logic dv, input logic [7:0] d);
        logic [18:0] e;
        @(negedge clk);
        donerx = dv;
        doutrx = dv ? d : 8'($urandom);
        @(posedge clk);
        model_step(dv, d);
        #1;
        e = exp_q.pop_front();
        check("cycle", {13'd0, mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err}, {13'd0, e});
        check("idle_flag", {31'd0, dbg_state == 2'd0}, {31'd0, frame_q.size() == 0});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        donerx = 1'b0;
        #1;
        check(name, {dbg_state, mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err},
              {2'd0, 2'd0, 7'd35, 7'd80, 1'b0, 1'b0, 1'b0});
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input string n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [1:0] em,
                           input logic [6:0] et, input logic [6:0] eh, input logic eo, input logic ee);
        tbl[i].name = n;
        tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2; tbl[i].b[3] = b3;
        tbl[i].e_mode = em; tbl[i].e_temp = et; tbl[i].e_hum = eh;
        tbl[i].e_ok = eo; tbl[i].e_err = ee;
    endtask

    initial begin
        // Bad-checksum frame A5 01 02 FF is a valid "mode 2" in the 3-byte build.
        m4 = CHK_ON ? 2'd1 : 2'd2;
        set_vec(0,  "temp40",   8'hA5, 8'h02, 8'h28, 8'h2A, 2'd0, 7'd40, 7'd80,  1'b1, 1'b0);
        set_vec(1,  "mode1",    8'hA5, 8'h01, 8'h01, 8'h00, 2'd1, 7'd40, 7'd80,  1'b1, 1'b0);
        set_vec(2,  "hum101",   8'hA5, 8'h03, 8'h65, 8'h66, 2'd1, 7'd40, 7'd80,  1'b0, 1'b1);
        set_vec(3,  "hum100",   8'hA5, 8'h03, 8'h64, 8'h67, 2'd1, 7'd40, 7'd100, 1'b1, 1'b0);
        set_vec(4,  "badchk",   8'hA5, 8'h01, 8'h02, 8'hFF, m4,   7'd40, 7'd100, ~CHK_ON, CHK_ON);
        set_vec(5,  "unknown",  8'hA5, 8'h07, 8'h00, 8'h07, m4,   7'd40, 7'd100, 1'b0, 1'b1);
        set_vec(6,  "temp85",   8'hA5, 8'h02, 8'h55, 8'h57, m4,   7'd85, 7'd100, 1'b1, 1'b0);
        set_vec(7,  "temp86",   8'hA5, 8'h02, 8'h56, 8'h54, m4,   7'd85, 7'd100, 1'b0, 1'b1);
        set_vec(8,  "temp_b7",  8'hA5, 8'h02, 8'hD5, 8'hD7, m4,   7'd85, 7'd100, 1'b0, 1'b1);
        set_vec(9,  "mode3",    8'hA5, 8'h01, 8'h03, 8'h02, m4,   7'd85, 7'd100, 1'b0, 1'b1);
        set_vec(10, "mode_hi",  8'hA5, 8'h01, 8'h04, 8'h05, m4,   7'd85, 7'd100, 1'b0, 1'b1);
        set_vec(11, "mode0",    8'hA5, 8'h01, 8'h00, 8'h01, 2'd0, 7'd85, 7'd100, 1'b1, 1'b0);
        set_vec(12, "hum0",     8'hA5, 8'h03, 8'h00, 8'h03, 2'd0, 7'd85, 7'd0,   1'b1, 1'b0);
        set_vec(13, "same85",   8'hA5, 8'h02, 8'h55, 8'h57, 2'd0, 7'd85, 7'd0,   1'b1, 1'b0);
        set_vec(14, "no_resync",8'hA5, 8'hA5, 8'h02, 8'hA7, 2'd0, 7'd85, 7'd0,   1'b0, 1'b1);
        set_vec(15, "hum30",    8'hA5, 8'h03, 8'h1E, 8'h1D, 2'd0, 7'd85, 7'd30,  1'b1, 1'b0);

        // Reset and idle
        rst = 1'b1;
        donerx = 1'b0;
        doutrx = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", {mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err},
              {2'd0, 7'd35, 7'd80, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        repeat (100) cycle(1'b0, 8'h00);
        check("idle100", {mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err},
              {2'd0, 7'd35, 7'd80, 1'b0, 1'b0, 1'b0});

        // Table of back-to-back frames, result checked one cycle after last byte
        t_exp = 1'b0;
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < FLEN; j++) cycle(1'b1, tbl[i].b[j]);
            if (tbl[i].e_ok) t_exp = ~t_exp;
            check(tbl[i].name, {mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err},
                  {tbl[i].e_mode, tbl[i].e_temp, tbl[i].e_hum, t_exp, tbl[i].e_ok, tbl[i].e_err});
        end

        // Inter-byte timeout, then the stranded tail bytes are discarded
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h02);
        repeat (T - 1) cycle(1'b0, 8'h00);
        check("timeout_early", {cmd_err, dbg_state != 2'd0}, {1'b1 ^ 1'b1, 1'b1});
        cycle(1'b0, 8'h00);
        check("timeout_fire", {cmd_err, dbg_state}, {1'b1, 2'd0});
        cycle(1'b1, 8'h28);
        cycle(1'b1, 8'h2A);
        check("discard", {cmd_ok, cmd_err, I_Temp_war, trig_newd12}, {1'b0, 1'b0, 7'd85, t_exp});

        // Byte arriving on the cycle the timeout would fire keeps the frame
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h02);
        repeat (T - 1) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h28);
        check("byte_wins", {31'd0, cmd_err}, 32'd0);
`ifdef CMD_CHECKSUM_EN
        cycle(1'b1, 8'h2A);
`endif
        t_exp = ~t_exp;
        check("byte_wins_ok", {cmd_ok, I_Temp_war, trig_newd12}, {1'b1, 7'd40, t_exp});

        // Reset in the middle of a frame
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h02);
`ifdef CMD_CHECKSUM_EN
        cycle(1'b1, 8'h28);
`endif
        do_reset("reset_mid");
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h02);
        cycle(1'b1, 8'h1E);
`ifdef CMD_CHECKSUM_EN
        cycle(1'b1, 8'h1C);
`endif
        check("after_reset", {mode, I_Temp_war, I_Hum_war, trig_newd12, cmd_ok, cmd_err},
              {2'd0, 7'd30, 7'd80, 1'b1, 1'b1, 1'b0});

        // Random frames, gaps around the timeout boundary, occasional noise
        for (int f = 0; f < 250; f++) begin
            fb[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : HDR;
            fb[1] = 8'($urandom_range(0, 4));
            fb[2] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 110)) : 8'($urandom);
            fb[3] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (fb[1] ^ fb[2]);
            for (int j = 0; j < FLEN; j++) begin
                gap = ($urandom_range(0, 19) == 0) ? (T - 2 + int'($urandom_range(0, 3)))
                                                   : int'($urandom_range(0, 2));
                repeat (gap) cycle(1'b0, 8'h00);
                cycle(1'b1, fb[j]);
            end
        end
        repeat (T + 2) cycle(1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
